// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - shared AXI4 burst/response codes and converter FSM state types
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_t;

  // Bit of the byte address that selects the 32-bit lane inside a 64-bit beat
  localparam int LANE_BIT = 2;

endpackage

// File: rtl/axi4_beat_addr_gen.sv
// rtl/axi4_beat_addr_gen.sv - combinational AXI4 next-beat byte address
module axi4_beat_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] bytes;
  logic [ADDR_W-1:0] span_mask;
  logic [ADDR_W-1:0] incr_addr;

  // Address of the following beat; full width kept so the carry into the lane bit is right
  always_comb begin
    bytes     = ADDR_W'(1) << size;
    span_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    incr_addr = addr + bytes;
    case (burst_t'(burst))
      FIXED:   next_addr = addr;
      INCR:    next_addr = incr_addr;
      WRAP:    next_addr = (addr & ~span_mask) | (incr_addr & span_mask);
      default: next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi4_data_width_converter_32to64.sv
// rtl/axi4_data_width_converter_32to64.sv - AXI4 32-bit initiator to 64-bit subordinate upsizer
module axi4_data_width_converter_32to64
  import axi4_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // 32-bit initiator side
  input  logic              in_arvalid,
  output logic              in_arready,
  input  logic [ID_W-1:0]   in_arid,
  input  logic [ADDR_W-1:0] in_araddr,
  input  logic [7:0]        in_arlen,
  input  logic [2:0]        in_arsize,
  input  logic [1:0]        in_arburst,
  output logic              in_rvalid,
  input  logic              in_rready,
  output logic [ID_W-1:0]   in_rid,
  output logic [31:0]       in_rdata,
  output logic [1:0]        in_rresp,
  output logic              in_rlast,
  input  logic              in_awvalid,
  output logic              in_awready,
  input  logic [ID_W-1:0]   in_awid,
  input  logic [ADDR_W-1:0] in_awaddr,
  input  logic [7:0]        in_awlen,
  input  logic [2:0]        in_awsize,
  input  logic [1:0]        in_awburst,
  input  logic              in_wvalid,
  output logic              in_wready,
  input  logic [31:0]       in_wdata,
  input  logic [3:0]        in_wstrb,
  input  logic              in_wlast,
  output logic              in_bvalid,
  input  logic              in_bready,
  output logic [ID_W-1:0]   in_bid,
  output logic [1:0]        in_bresp,
  // 64-bit subordinate side
  output logic              out_arvalid,
  input  logic              out_arready,
  output logic [ID_W-1:0]   out_arid,
  output logic [ADDR_W-1:0] out_araddr,
  output logic [7:0]        out_arlen,
  output logic [2:0]        out_arsize,
  output logic [1:0]        out_arburst,
  input  logic              out_rvalid,
  output logic              out_rready,
  input  logic [ID_W-1:0]   out_rid,
  input  logic [63:0]       out_rdata,
  input  logic [1:0]        out_rresp,
  input  logic              out_rlast,
  output logic              out_awvalid,
  input  logic              out_awready,
  output logic [ID_W-1:0]   out_awid,
  output logic [ADDR_W-1:0] out_awaddr,
  output logic [7:0]        out_awlen,
  output logic [2:0]        out_awsize,
  output logic [1:0]        out_awburst,
  output logic              out_wvalid,
  input  logic              out_wready,
  output logic [63:0]       out_wdata,
  output logic [7:0]        out_wstrb,
  output logic              out_wlast,
  input  logic              out_bvalid,
  output logic              out_bready,
  input  logic [ID_W-1:0]   out_bid,
  input  logic [1:0]        out_bresp
);

  rd_state_t         rd_state_q, rd_state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_next;
  logic [2:0]        rd_size_q, rd_size_d;
  logic [7:0]        rd_len_q, rd_len_d;
  logic [1:0]        rd_burst_q, rd_burst_d;

  wr_state_t         wr_state_q, wr_state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, wr_next;
  logic [2:0]        wr_size_q, wr_size_d;
  logic [7:0]        wr_len_q, wr_len_d;
  logic [1:0]        wr_burst_q, wr_burst_d;

  axi4_beat_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
    .addr      (rd_addr_q),
    .size      (rd_size_q),
    .len       (rd_len_q),
    .burst     (rd_burst_q),
    .next_addr (rd_next)
  );

  axi4_beat_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
    .addr      (wr_addr_q),
    .size      (wr_size_q),
    .len       (wr_len_q),
    .burst     (wr_burst_q),
    .next_addr (wr_next)
  );

  // Address, ID and response fields are pure wires; only the handshakes are gated
  assign out_arid    = in_arid;
  assign out_araddr  = in_araddr;
  assign out_arlen   = in_arlen;
  assign out_arsize  = in_arsize;
  assign out_arburst = in_arburst;
  assign in_rid      = out_rid;
  assign in_rresp    = out_rresp;
  assign in_rlast    = out_rlast;
  assign in_rdata    = rd_addr_q[LANE_BIT] ? out_rdata[63:32] : out_rdata[31:0];

  assign out_awid    = in_awid;
  assign out_awaddr  = in_awaddr;
  assign out_awlen   = in_awlen;
  assign out_awsize  = in_awsize;
  assign out_awburst = in_awburst;
  assign out_wdata   = {in_wdata, in_wdata};
  assign out_wstrb   = wr_addr_q[LANE_BIT] ? {in_wstrb, 4'h0} : {4'h0, in_wstrb};
  assign out_wlast   = in_wlast;
  assign in_bid      = out_bid;
  assign in_bresp    = out_bresp;

  // Read FSM: handshake gating (forced low during reset) and beat address tracking
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_addr_d   = rd_addr_q;
    rd_size_d   = rd_size_q;
    rd_len_d    = rd_len_q;
    rd_burst_d  = rd_burst_q;
    out_arvalid = rst_n & in_arvalid  & (rd_state_q == R_IDLE);
    in_arready  = rst_n & out_arready & (rd_state_q == R_IDLE);
    in_rvalid   = rst_n & out_rvalid  & (rd_state_q == R_DATA);
    out_rready  = rst_n & in_rready   & (rd_state_q == R_DATA);
    case (rd_state_q)
      R_IDLE: begin
        if (in_arvalid && out_arready) begin
          rd_addr_d  = in_araddr;
          rd_size_d  = in_arsize;
          rd_len_d   = in_arlen;
          rd_burst_d = in_arburst;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (out_rvalid && in_rready) begin
          rd_addr_d = rd_next;
          if (out_rlast) rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write FSM: W held off until its AW is accepted, B only passed in W_RESP
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_addr_d   = wr_addr_q;
    wr_size_d   = wr_size_q;
    wr_len_d    = wr_len_q;
    wr_burst_d  = wr_burst_q;
    out_awvalid = rst_n & in_awvalid  & (wr_state_q == W_IDLE);
    in_awready  = rst_n & out_awready & (wr_state_q == W_IDLE);
    out_wvalid  = rst_n & in_wvalid   & (wr_state_q == W_DATA);
    in_wready   = rst_n & out_wready  & (wr_state_q == W_DATA);
    in_bvalid   = rst_n & out_bvalid  & (wr_state_q == W_RESP);
    out_bready  = rst_n & in_bready   & (wr_state_q == W_RESP);
    case (wr_state_q)
      W_IDLE: begin
        if (in_awvalid && out_awready) begin
          wr_addr_d  = in_awaddr;
          wr_size_d  = in_awsize;
          wr_len_d   = in_awlen;
          wr_burst_d = in_awburst;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (in_wvalid && out_wready) begin
          wr_addr_d = wr_next;
          if (in_wlast) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (out_bvalid && in_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // State registers for both channels; reset abandons any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_size_q  <= '0;
      rd_len_q   <= '0;
      rd_burst_q <= '0;
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_size_q  <= '0;
      wr_len_q   <= '0;
      wr_burst_q <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_size_q  <= rd_size_d;
      rd_len_q   <= rd_len_d;
      rd_burst_q <= rd_burst_d;
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_size_q  <= wr_size_d;
      wr_len_q   <= wr_len_d;
      wr_burst_q <= wr_burst_d;
    end
  end

  ar_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
    (in_arvalid && in_arready) |-> (in_arsize <= 3'd2 && in_arburst != 2'b11));

  aw_legal_a: assert property (@(posedge clk) disable iff (!rst_n)
    (in_awvalid && in_awready) |-> (in_awsize <= 3'd2 && in_awburst != 2'b11));

endmodule
